// File: rtl/usb_rx_timer.sv
// USB receive bit timer: recovers bit phase from line edges, strobes each bit and frames bytes.
// Optional `USB_RX_IDLE_TIMEOUT_EN adds a no-edge watchdog that ends reception with rx_error.
module usb_rx_timer #(
  parameter int CLKS_PER_BIT = 8,
  parameter int SAMPLE_POINT = 3,
  parameter int MAX_BYTES    = 64
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       rcving,
  input  logic       d_edge,
  input  logic       stuff_bit,
  input  logic       eop,
  output logic       shift_enable,
  output logic       byte_received,
  output logic [7:0] byte_count,
  output logic       rx_done,
  output logic       rx_overflow,
  output logic       rx_error
);

  typedef enum logic [1:0] {IDLE, SYNC, RUN, DONE} state_t;

  localparam logic [3:0] SAMPLE_W = 4'(SAMPLE_POINT);
  localparam logic [3:0] WRAP_W   = 4'(CLKS_PER_BIT - 1);
  localparam logic [7:0] MAX_B    = 8'(MAX_BYTES);

  state_t     state_q, state_d;
  logic [3:0] wcnt_q, wcnt_d;
  logic [2:0] bcnt_q, bcnt_d;
  logic [7:0] cnt_q, cnt_d;
  logic       brx_q, brx_d;
  logic       ovf_q, ovf_d;
  logic       err_q, err_d;
  logic       strobe;
  logic       timeout;

  assign strobe = (state_q == RUN) && (wcnt_q == SAMPLE_W) && !eop;

`ifdef USB_RX_IDLE_TIMEOUT_EN
  localparam logic [7:0] IDLE_LIMIT = 8'(8 * CLKS_PER_BIT - 1);
  logic [7:0] idle_q, idle_d;

  always_comb begin
    idle_d  = idle_q + 8'd1;
    timeout = (state_q == RUN) && !d_edge && (idle_q == IDLE_LIMIT);
    if (state_q != RUN || d_edge) begin
      idle_d = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      idle_q <= 8'd0;
    end else begin
      idle_q <= idle_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    bcnt_d  = bcnt_q;
    cnt_d   = cnt_q;
    brx_d   = 1'b0;
    ovf_d   = ovf_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (rcving) begin
          state_d = SYNC;
        end
      end
      SYNC: begin
        if (d_edge) begin
          state_d = RUN;
          wcnt_d  = 4'd0;
        end
      end
      RUN: begin
        if (d_edge || wcnt_q == WRAP_W) begin
          wcnt_d = 4'd0;
        end else begin
          wcnt_d = wcnt_q + 4'd1;
        end
        if (strobe && !stuff_bit) begin
          bcnt_d = bcnt_q + 3'd1;
          if (bcnt_q == 3'd7) begin
            if (cnt_q < MAX_B) begin
              cnt_d = cnt_q + 8'd1;
              brx_d = 1'b1;
            end else begin
              ovf_d = 1'b1;
            end
          end
        end
        // strobe is already masked by eop, so bcnt_q here is the final bit position
        if (eop) begin
          state_d = DONE;
          if (bcnt_q != 3'd0) begin
            err_d = 1'b1;
          end
        end
        if (timeout) begin
          state_d = DONE;
          err_d   = 1'b1;
        end
      end
      default: ;
    endcase
    if (!rcving) begin
      state_d = IDLE;
      wcnt_d  = 4'd0;
      bcnt_d  = 3'd0;
      cnt_d   = 8'd0;
      brx_d   = 1'b0;
      ovf_d   = 1'b0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= IDLE;
      wcnt_q  <= 4'd0;
      bcnt_q  <= 3'd0;
      cnt_q   <= 8'd0;
      brx_q   <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      bcnt_q  <= bcnt_d;
      cnt_q   <= cnt_d;
      brx_q   <= brx_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  assign shift_enable  = strobe;
  assign byte_received = brx_q;
  assign byte_count    = cnt_q;
  assign rx_done       = (state_q == DONE);
  assign rx_overflow   = ovf_q;
  assign rx_error      = err_q;

endmodule
